// File: rtl/mdr_pkg.sv
// Shared defaults for the memory data register buffer between memory and fetch.
package mdr_pkg;

    localparam int unsigned MDR_WIDTH_DEFAULT = 36;
    localparam int unsigned MDR_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/mdr_ptr.sv
// Wrapping pointer for the MDR buffer: counts 0..DEPTH-1, synchronous clear wins over increment.
module mdr_ptr
    import mdr_pkg::*;
#(
    parameter int unsigned DEPTH = MDR_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     inc,
    input  logic                     clr,
    output logic [$clog2(DEPTH)-1:0] ptr
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            // Explicit wrap so non-power-of-two depths never reach unused slots.
            ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/mdr_buffer.sv
// Small FIFO holding words returned by memory until the fetch stage consumes them.
module mdr_buffer
    import mdr_pkg::*;
#(
    parameter int unsigned WIDTH = MDR_WIDTH_DEFAULT,
    parameter int unsigned DEPTH = MDR_DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       wr_ready,
    output logic                       rd_valid,
    output logic [WIDTH-1:0]           rd_data,
    input  logic                       rd_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             push;
    logic             pop;

    // Handshakes come from registered state only, so a full buffer never takes a word
    // even when a pop frees a slot in the same cycle.
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign wr_ready = !full;
    assign rd_valid = !empty;
    assign push     = wr_valid && wr_ready;
    assign pop      = rd_valid && rd_ready;

    mdr_ptr #(
        .DEPTH (DEPTH)
    ) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (push),
        .clr   (flush),
        .ptr   (wr_ptr)
    );

    mdr_ptr #(
        .DEPTH (DEPTH)
    ) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pop),
        .clr   (flush),
        .ptr   (rd_ptr)
    );

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (flush) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
            if (wr_valid && full) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage is deliberately unreset; the output mux hides it while empty.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = empty ? '0 : mem[rd_ptr];
    assign count   = count_q;
    assign ovf_err = ovf_q;

endmodule

// File: tb/tb_mdr_buffer.sv
// Directed bench for mdr_buffer: default DEPTH=4 instance plus a DEPTH=3 instance.
module tb_mdr_buffer;

    logic        clk;
    logic        rst_n;

    logic        wr_valid;
    logic [35:0] wr_data;
    logic        wr_ready;
    logic        rd_valid;
    logic [35:0] rd_data;
    logic        rd_ready;
    logic        flush;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic        ovf_err;

    logic        wr_valid3;
    logic [35:0] wr_data3;
    logic        wr_ready3;
    logic        rd_valid3;
    logic [35:0] rd_data3;
    logic        rd_ready3;
    logic        flush3;
    logic [1:0]  count3;
    logic        full3;
    logic        empty3;
    logic        ovf_err3;

    int checks = 0;
    int errors = 0;

    mdr_buffer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_ready (rd_ready),
        .flush    (flush),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .ovf_err  (ovf_err)
    );

    mdr_buffer #(
        .WIDTH (36),
        .DEPTH (3)
    ) dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid3),
        .wr_data  (wr_data3),
        .wr_ready (wr_ready3),
        .rd_valid (rd_valid3),
        .rd_data  (rd_data3),
        .rd_ready (rd_ready3),
        .flush    (flush3),
        .count    (count3),
        .full     (full3),
        .empty    (empty3),
        .ovf_err  (ovf_err3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [35:0] seq_word(input int i);
        return 36'h1_0000_0000 + 36'(i);
    endfunction

    logic [35:0] w4 [4];

    initial begin
        w4[0] = 36'h0_AAAA_0001;
        w4[1] = 36'h0_BBBB_0002;
        w4[2] = 36'h0_CCCC_0003;
        w4[3] = 36'h0_DDDD_0004;

        rst_n     = 1'b0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;
        flush     = 1'b0;
        wr_valid3 = 1'b0;
        wr_data3  = '0;
        rd_ready3 = 1'b0;
        flush3    = 1'b0;

        // Reset values
        #2;
        check("rst_count", 64'(count), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_wr_ready", 64'(wr_ready), 64'd1);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        check("rst_ovf", 64'(ovf_err), 64'd0);
        #10;
        rst_n = 1'b1;
        step();

        // Single push: visible one cycle later
        wr_valid = 1'b1;
        wr_data  = 36'h0_1234_5678;
        step();
        wr_valid = 1'b0;
        check("p1_rd_valid", 64'(rd_valid), 64'd1);
        check("p1_rd_data", 64'(rd_data), 64'h0_1234_5678);
        check("p1_count", 64'(count), 64'd1);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        check("p1_empty", 64'(empty), 64'd1);
        check("p1_rd_data_zero", 64'(rd_data), 64'd0);

        // Fill, overflow attempt, drain
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data  = w4[i];
            step();
        end
        wr_valid = 1'b0;
        check("fill_full", 64'(full), 64'd1);
        check("fill_wr_ready", 64'(wr_ready), 64'd0);
        check("fill_count", 64'(count), 64'd4);
        check("fill_ovf_clear", 64'(ovf_err), 64'd0);
        wr_valid = 1'b1;
        wr_data  = 36'h0_EEEE_0005;
        step();
        wr_valid = 1'b0;
        check("ovf_set", 64'(ovf_err), 64'd1);
        check("ovf_count", 64'(count), 64'd4);
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_%0d", i), 64'(rd_data), 64'(w4[i]));
            step();
        end
        rd_ready = 1'b0;
        check("drain_empty", 64'(empty), 64'd1);
        check("ovf_sticky", 64'(ovf_err), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_ovf_clear", 64'(ovf_err), 64'd0);

        // Steady push+pop at count 2 across pointer wrap
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1;
            wr_data  = seq_word(i);
            step();
        end
        for (int i = 0; i < 10; i++) begin
            wr_valid = 1'b1;
            wr_data  = seq_word(i + 2);
            rd_ready = 1'b1;
            check($sformatf("stream_data_%0d", i), 64'(rd_data), 64'(seq_word(i)));
            step();
            check($sformatf("stream_count_%0d", i), 64'(count), 64'd2);
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;

        // Full with simultaneous pop: the push is refused
        for (int i = 12; i < 14; i++) begin
            wr_valid = 1'b1;
            wr_data  = seq_word(i);
            step();
        end
        check("full2_count", 64'(count), 64'd4);
        wr_valid = 1'b1;
        wr_data  = 36'h0_DEAD_BEEF;
        rd_ready = 1'b1;
        step();
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        check("fullpop_count", 64'(count), 64'd3);
        check("fullpop_ovf", 64'(ovf_err), 64'd1);
        check("fullpop_head", 64'(rd_data), 64'(seq_word(11)));

        // Flush beats simultaneous push and pop
        flush    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 36'h0_0BAD_0BAD;
        rd_ready = 1'b1;
        step();
        flush    = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        check("flush_count", 64'(count), 64'd0);
        check("flush_empty", 64'(empty), 64'd1);
        check("flush_ovf", 64'(ovf_err), 64'd0);
        check("flush_rd_data", 64'(rd_data), 64'd0);
        check("flush_rd_valid", 64'(rd_valid), 64'd0);

        // Asynchronous reset mid-cycle with words in flight
        for (int i = 20; i < 22; i++) begin
            wr_valid = 1'b1;
            wr_data  = seq_word(i);
            step();
        end
        wr_valid = 1'b0;
        check("pre_arst_count", 64'(count), 64'd2);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_count", 64'(count), 64'd0);
        check("arst_empty", 64'(empty), 64'd1);
        check("arst_full", 64'(full), 64'd0);
        check("arst_wr_ready", 64'(wr_ready), 64'd1);
        check("arst_rd_valid", 64'(rd_valid), 64'd0);
        check("arst_rd_data", 64'(rd_data), 64'd0);
        #1;
        rst_n = 1'b1;
        wr_valid = 1'b1;
        wr_data  = seq_word(30);
        step();
        wr_valid = 1'b0;
        check("post_rst_head", 64'(rd_data), 64'(seq_word(30)));
        check("post_rst_count", 64'(count), 64'd1);

        // DEPTH=3: interleaved push/pop through non-power-of-two wrap
        wr_valid3 = 1'b1;
        wr_data3  = seq_word(100);
        step();
        for (int i = 1; i < 7; i++) begin
            wr_data3  = seq_word(100 + i);
            rd_ready3 = 1'b1;
            check($sformatf("d3_inter_%0d", i), 64'(rd_data3), 64'(seq_word(100 + i - 1)));
            step();
            check($sformatf("d3_count_%0d", i), 64'(count3), 64'd1);
        end
        wr_valid3 = 1'b0;
        check("d3_last", 64'(rd_data3), 64'(seq_word(106)));
        step();
        rd_ready3 = 1'b0;
        check("d3_empty", 64'(empty3), 64'd1);
        for (int i = 0; i < 3; i++) begin
            wr_valid3 = 1'b1;
            wr_data3  = seq_word(200 + i);
            step();
        end
        wr_valid3 = 1'b0;
        check("d3_full", 64'(full3), 64'd1);
        check("d3_full_count", 64'(count3), 64'd3);
        check("d3_wr_ready", 64'(wr_ready3), 64'd0);
        rd_ready3 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("d3_drain_%0d", i), 64'(rd_data3), 64'(seq_word(200 + i)));
            step();
        end
        rd_ready3 = 1'b0;
        check("d3_drain_empty", 64'(empty3), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdr_buffer.md
MDR_BUFFER -- requirements
Module: mdr_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 36, memory data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, number of buffered words (>=2, need not be a power of 2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port wr_valid  input  1  memory side presents a word.
REQ-006 SHALL have port wr_data  input  WIDTH  word from memory.
REQ-007 SHALL have port wr_ready  output  1  buffer can accept a word.
REQ-008 SHALL have port rd_valid  output  1  buffer holds a word for fetch stage.
REQ-009 SHALL have port rd_data  output  WIDTH  oldest buffered word.
REQ-010 SHALL have port rd_ready  input  1  fetch stage consumes rd_data.
REQ-011 SHALL have port flush  input  1  discard all buffered words (branch/redirect).
REQ-012 SHALL have port count  output  $clog2(DEPTH+1)  words currently held.
REQ-013 SHALL have port full  output  1  count==DEPTH.
REQ-014 SHALL have port empty  output  1  count==0.
REQ-015 SHALL have port ovf_err  output  1  sticky: write attempted while full.

Function
REQ-016 SHALL accept a push iff wr_valid && wr_ready in a cycle; the word is stored at the write pointer on that edge.
REQ-017 SHALL perform a pop iff rd_valid && rd_ready; the read pointer advances on that edge.
REQ-018 SHALL drive wr_ready = !full and rd_valid = !empty, both derived from registered state only (no combinational path from wr_valid/rd_ready).
REQ-019 SHALL present rd_data = the entry at the read pointer when !empty, and all-zeros when empty.
REQ-020 SHALL give push-to-rd_valid latency of exactly 1 cycle: a word pushed into an empty buffer is visible on the next cycle.
REQ-021 SHALL, on simultaneous push and pop with 0<count<DEPTH, keep count unchanged and advance both pointers.
REQ-022 SHALL NOT accept a push when full, even if a pop occurs in the same cycle; a word cannot bypass an empty buffer.
REQ-023 SHALL wrap each pointer from DEPTH-1 to 0; count SHALL update +1 on push only, -1 on pop only.
REQ-024 SHALL preserve FIFO order: words leave in push order with no loss or duplication.
REQ-025 SHALL, when flush=1, on that edge set count=0, both pointers=0 and ovf_err=0, ignoring any push or pop that cycle; storage contents need not be cleared.
REQ-026 SHALL set ovf_err when wr_valid && full; it SHALL hold until flush or reset.

Reset
REQ-027 SHALL, while rst_n=0 (asynchronously), force pointers=0, count=0, empty=1, full=0, wr_ready=1, rd_valid=0, rd_data=0, ovf_err=0.
REQ-028 SHALL leave storage array contents unreset; outputs SHALL not depend on them while empty.
REQ-029 SHALL abandon any in-flight words on reset mid-operation; the first post-reset push SHALL be the first word read.

Structure
REQ-030 SHALL place MDR_WIDTH_DEFAULT (36) and MDR_DEPTH_DEFAULT (4) in the shared package mdr_pkg.
REQ-031 SHALL implement each pointer as an instance of sub-module mdr_ptr (parametrised DEPTH wrap counter with inc and clr inputs).

Verification
REQ-032 Reset then push 36'h0_1234_5678 -> rd_valid=1 next cycle, rd_data=36'h0_1234_5678, count=1.
REQ-033 Push 4 words A,B,C,D with rd_ready=0 -> full=1, wr_ready=0, count=4; 5th wr_valid -> ovf_err=1, word dropped; drain -> A,B,C,D.
REQ-034 With count=2, push and pop together for 10 cycles -> count stays 2, order preserved across pointer wrap.
REQ-035 DEPTH=3 instance: push 7, pop 7 interleaved -> correct order through non-power-of-2 wrap.
REQ-036 Count=3, assert flush with wr_valid=1 and rd_ready=1 -> next cycle count=0, empty=1, ovf_err=0, rd_data=0.
REQ-037 Deassert rst_n asynchronously between edges with count=2 -> outputs at reset values immediately, before the next clk edge.
